// File: rtl/multicycle_main_fsm.sv
// Main control sequencer for the multicycle ARMv4 core: steps FETCH/DECODE/EXEC/MEM/WB over 2-5 cycles.
// Latency: 0-cycle Moore strobes from the state register; state advances one step per rising edge.
// Backpressure: FETCH, MEMRD and MEMWR hold while MemReady=0 and emit no strobes until it rises.
module multicycle_main_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [3:0]         Rd,
    input  logic               MemReady,
    output logic               IRWrite,
    output logic               NextPC,
    output logic               AdrSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic               ALUOp,
    output logic               RegW,
    output logic               MemW,
    output logic               Branch,
    output logic               PCS,
    output logic               InstrDone,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t r_state;
    state_t w_next;

    // Only the I bit and the L/S bit steer the sequence; the ALU command bits go to the ALU decoder.
    logic w_unused_funct;
    assign w_unused_funct = ^Funct[4:1];

    // State register; reset wins over any pending transition, including a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection; memory states hold until MemReady.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    2'b01:   w_next = S_MEMADR;
                    2'b00:   w_next = Funct[5] ? S_EXECI : S_EXECR;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_FETCH;   // undefined opcode retires as a NOP
                endcase
            end
            S_MEMADR: w_next = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  w_next = MemReady ? S_FETCH : S_MEMWR;
            S_EXECR:  w_next = S_ALUWB;
            S_EXECI:  w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    // Moore control strobes; while reset is held the FETCH datapath setup is shown with no writes.
    always_comb begin
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUOp     = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        InstrDone = 1'b0;
        if (reset) begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
        end else begin
            case (r_state)
                S_FETCH: begin
                    IRWrite   = MemReady;     // a stalled fetch must not advance the PC
                    NextPC    = MemReady;
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
                S_DECODE: begin
                    ALUSrcA   = 2'b01;        // PC+8 for R15 operand reads
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    InstrDone = (Op == 2'b11); // undefined opcode finishes here
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b00;
                    ALUSrcB = 2'b01;
                end
                S_MEMRD: begin
                    AdrSrc = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegW      = 1'b1;
                    InstrDone = 1'b1;
                end
                S_MEMWR: begin
                    AdrSrc    = 1'b1;
                    MemW      = MemReady;
                    InstrDone = MemReady;
                end
                S_EXECR: begin
                    ALUSrcA = 2'b00;
                    ALUSrcB = 2'b00;
                    ALUOp   = 1'b1;
                end
                S_EXECI: begin
                    ALUSrcA = 2'b00;
                    ALUSrcB = 2'b01;
                    ALUOp   = 1'b1;
                end
                S_ALUWB: begin
                    ResultSrc = 2'b00;
                    RegW      = 1'b1;
                    InstrDone = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA   = 2'b10;
                    ALUSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                    Branch    = 1'b1;
                    InstrDone = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign PCS   = Branch | (RegW & (Rd == 4'hF));
    assign State = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Bench for multicycle_main_fsm: directed instruction scenarios plus randomized instruction/stall mix.
// Each instruction is expanded into its expected state path; every cycle is compared against a table.
// Stalls are injected in FETCH/MEMRD/MEMWR by holding MemReady low for a chosen number of cycles.
module tb_multicycle_main_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       MemReady;
    logic       IRWrite, NextPC, AdrSrc, ALUOp, RegW, MemW, Branch, PCS, InstrDone;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] State;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    multicycle_main_fsm #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .MemReady(MemReady),
        .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .RegW(RegW),
        .MemW(MemW), .Branch(Branch), .PCS(PCS), .InstrDone(InstrDone), .State(State)
    );

    wire [14:0] act = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                       ALUOp, RegW, MemW, Branch, PCS, InstrDone};

    // Expected strobes for a named control step, straight from the per-state output table.
    function automatic logic [14:0] exp_out(input int st, input bit mr, input bit rst,
                                            input logic [3:0] rd, input logic [1:0] op);
        logic irw, npc, adr, aop, rw, mw, br, dn;
        logic [1:0] a, b, r;
        int s;
        irw = 0; npc = 0; adr = 0; aop = 0; rw = 0; mw = 0; br = 0; dn = 0;
        a = 2'b00; b = 2'b00; r = 2'b00;
        s = rst ? 0 : st;
        case (s)
            0: begin irw = mr && !rst; npc = mr && !rst; a = 2'b01; b = 2'b10; r = 2'b10; end
            1: begin a = 2'b01; b = 2'b10; r = 2'b10; dn = (op == 2'b11); end
            2: begin a = 2'b00; b = 2'b01; end
            3: begin adr = 1; end
            4: begin r = 2'b01; rw = 1; dn = 1; end
            5: begin adr = 1; mw = mr; dn = mr; end
            6: begin aop = 1; end
            7: begin b = 2'b01; aop = 1; end
            8: begin rw = 1; dn = 1; end
            9: begin a = 2'b10; b = 2'b01; r = 2'b10; br = 1; dn = 1; end
            default: begin end
        endcase
        return {irw, npc, adr, a, b, r, aop, rw, mw, br, br | (rw && rd == 4'hF), dn};
    endfunction

    // Runs one instruction from FETCH. fst/mst = stall cycles in FETCH / memory state (-1 = random).
    // Returns DUT-observed strobe counts and the cycle index at which InstrDone was seen.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                             input int fst, input int mst,
                             output int done_idx, output int npc_n, output int rw_n,
                             output int mw_n, output int dn_n, output int pcs_n);
        int path[$];
        int cyc;
        Op = op; Funct = f; Rd = rd;
        path.push_back(0);
        path.push_back(1);
        if (op == 2'b01) begin
            path.push_back(2);
            if (f[0]) begin path.push_back(3); path.push_back(4); end
            else path.push_back(5);
        end else if (op == 2'b00) begin
            path.push_back(f[5] ? 7 : 6);
            path.push_back(8);
        end else if (op == 2'b10) begin
            path.push_back(9);
        end
        cyc = 0; done_idx = -1; npc_n = 0; rw_n = 0; mw_n = 0; dn_n = 0; pcs_n = 0;
        foreach (path[i]) begin
            int  st;
            bit  is_mem;
            int  stalls;
            st     = path[i];
            is_mem = (st == 0 || st == 3 || st == 5);
            stalls = 0;
            if (is_mem) begin
                stalls = (st == 0) ? fst : mst;
                if (stalls < 0) stalls = int'($urandom_range(0, 3));
            end
            for (int k = 0; k <= stalls; k++) begin
                bit mr;
                logic [14:0] e;
                mr = is_mem ? (k == stalls) : bit'($urandom_range(0, 1));
                MemReady = mr;
                @(negedge clk);
                vectors++;
                if (State !== 4'(st)) begin
                    miscompares++;
                    $display("FAIL state op=%b f=%b cyc=%0d: got %0d expected %0d", op, f, cyc, State, st);
                end
                e = exp_out(st, mr, 1'b0, rd, op);
                vectors++;
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL strobes st=%0d mr=%0b cyc=%0d: got %h expected %h", st, mr, cyc, act, e);
                end
                npc_n += int'(NextPC);
                rw_n  += int'(RegW);
                mw_n  += int'(MemW);
                pcs_n += int'(PCS);
                if (InstrDone === 1'b1) begin dn_n++; done_idx = cyc; end
                cyc++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; MemReady = 1'b1; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if (State !== 4'd0 || IRWrite !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold: state=%0d irwrite=%b expected 0/0", State, IRWrite);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (State !== 4'd0 || IRWrite !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: state=%0d irwrite=%b expected 0/1", State, IRWrite);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_add;
        int di, np, rw, mw, dn, pc;
        run_instr(2'b00, 6'b001000, 4'd1, 0, 0, di, np, rw, mw, dn, pc);
        vectors++;
        if (di !== 3 || rw !== 1 || dn !== 1) begin
            miscompares++;
            $display("FAIL add: done_idx=%0d regw=%0d done=%0d expected 3/1/1", di, rw, dn);
        end
    endtask

    task automatic test_ldr_stall;
        int di, np, rw, mw, dn, pc;
        run_instr(2'b01, 6'b011001, 4'd2, 2, 3, di, np, rw, mw, dn, pc);
        vectors++;
        if (di !== 9 || np !== 1 || rw !== 1) begin
            miscompares++;
            $display("FAIL ldr_stall: done_idx=%0d nextpc=%0d regw=%0d expected 9/1/1", di, np, rw);
        end
    endtask

    task automatic test_str_stall;
        int di, np, rw, mw, dn, pc;
        run_instr(2'b01, 6'b011000, 4'd4, 0, 1, di, np, rw, mw, dn, pc);
        vectors++;
        if (mw !== 1 || rw !== 0 || di !== 4) begin
            miscompares++;
            $display("FAIL str_stall: memw=%0d regw=%0d done_idx=%0d expected 1/0/4", mw, rw, di);
        end
    endtask

    task automatic test_branch_movpc;
        int di, np, rw, mw, dn, pc;
        run_instr(2'b10, 6'b010000, 4'd0, 0, 0, di, np, rw, mw, dn, pc);
        vectors++;
        if (di !== 2 || pc !== 1) begin
            miscompares++;
            $display("FAIL branch: done_idx=%0d pcs=%0d expected 2/1", di, pc);
        end
        run_instr(2'b00, 6'b011010, 4'hF, 0, 0, di, np, rw, mw, dn, pc);
        vectors++;
        if (pc !== 1 || di !== 3) begin
            miscompares++;
            $display("FAIL mov_pc: pcs=%0d done_idx=%0d expected 1/3", pc, di);
        end
    endtask

    task automatic test_undef_and_reset_mid_stall;
        int di, np, rw, mw, dn, pc;
        logic [14:0] e;
        run_instr(2'b11, 6'b000000, 4'd5, 0, 0, di, np, rw, mw, dn, pc);
        vectors++;
        if (di !== 1 || dn !== 1) begin
            miscompares++;
            $display("FAIL undef: done_idx=%0d done=%0d expected 1/1", di, dn);
        end
        // LDR walked into a MEMRD stall, then reset
        Op = 2'b01; Funct = 6'b011001; Rd = 4'd3; MemReady = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        MemReady = 1'b0;
        @(negedge clk);
        vectors++;
        if (State !== 4'd3) begin
            miscompares++;
            $display("FAIL memrd_stall: state=%0d expected 3", State);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        e = exp_out(3, 1'b0, 1'b1, 4'd3, 2'b01);
        vectors++;
        if (act !== e) begin
            miscompares++;
            $display("FAIL reset_strobes: got %h expected %h", act, e);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (State !== 4'd0 || RegW !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_stall: state=%0d regw=%b expected 0/0", State, RegW);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        int di, np, rw, mw, dn, pc;
        for (int n = 0; n < 40; n++) begin
            logic [1:0] op;
            logic [5:0] f;
            logic [3:0] rd;
            op = 2'($urandom);
            f  = 6'($urandom);
            rd = 4'($urandom);
            run_instr(op, f, rd, -1, -1, di, np, rw, mw, dn, pc);
            vectors++;
            if (dn !== 1 || np !== 1) begin
                miscompares++;
                $display("FAIL random_instr op=%b f=%b: done=%0d nextpc=%0d expected 1/1", op, f, dn, np);
            end
        end
    endtask

    initial begin
        reset = 1'b1; MemReady = 1'b0; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
        @(posedge clk); #1;
        test_reset();
        test_add();
        test_ldr_stall();
        test_str_stall();
        test_branch_movpc();
        test_undef_and_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
